// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned 8x8 multiply / 8/8 divide sequencer driving an external
// combinational adder/subtractor, one adder pass per bit over 8 RUN cycles.
module mul_div_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       op,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       div_by_zero,
  output logic [7:0] adder_a,
  output logic [7:0] adder_b,
  output logic       adder_mode,
  input  logic [7:0] adder_sum,
  input  logic       adder_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] count, count_nxt;
  logic [7:0] hi, hi_nxt, lo, lo_nxt, b_reg, b_nxt;
  logic       op_reg, op_nxt, dbz, dbz_nxt;
  logic [7:0] rem_shift;
  logic       div_accept;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign result_hi   = hi;
  assign result_lo   = lo;
  assign div_by_zero = dbz;

  // Partial remainder after shifting in the next dividend bit; hi[7] is its 9th bit.
  assign rem_shift  = {hi[6:0], lo[7]};
  assign div_accept = hi[7] | adder_cout;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    hi_nxt     = hi;
    lo_nxt     = lo;
    b_nxt      = b_reg;
    op_nxt     = op_reg;
    dbz_nxt    = dbz;
    adder_a    = '0;
    adder_b    = '0;
    adder_mode = 1'b1;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = RUN;
          count_nxt = '0;
          hi_nxt    = '0;
          lo_nxt    = operand_a;
          b_nxt     = operand_b;
          op_nxt    = op;
          dbz_nxt   = op && (operand_b == '0);
        end
      end
      RUN: begin
        adder_b = b_reg;
        if (!op_reg) begin
          adder_a    = hi;
          adder_mode = 1'b1;
          if (lo[0]) {hi_nxt, lo_nxt} = {adder_cout, adder_sum, lo[7:1]};
          else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[7:1]};
        end else begin
          adder_a    = rem_shift;
          adder_mode = 1'b0;
          hi_nxt     = div_accept ? adder_sum : rem_shift;
          lo_nxt     = {lo[6:0], div_accept};
        end
        count_nxt = count + 3'd1;
        if (count == 3'd7) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      b_reg  <= b_nxt;
      op_reg <= op_nxt;
      dbz    <= dbz_nxt;
    end
  end

endmodule
